// File: rtl/sprite_attr_writer.sv
// Decodes 24-bit host commands into sprite/texture attribute RAM writes.
// A per-sprite shadow bank supplies the untouched bits of each merged word.
module sprite_attr_writer #(
  parameter int         SPR_W     = 5,
  parameter int         TEX_W     = 5,
  parameter int         YS_W      = 4,
  parameter logic [7:0] OP_CLRALL = 8'd36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [23:0]           cmd,
  output logic                  cmd_ready,
  output logic                  wx,
  output logic [TEX_W+YS_W-1:0] waddrx,
  output logic [31:0]           savex,
  output logic                  busy,
  output logic                  rdy
);

  localparam int ADDR_W = TEX_W + YS_W;
  localparam int SH_W   = SPR_W + 1;
  localparam int SH_N   = 2 ** SH_W;

  localparam logic [7:0] OP_TEXSEL = 8'd18;
  localparam logic [7:0] OP_YSEL   = 8'd19;
  localparam logic [7:0] OP_TEXLO  = 8'd20;
  localparam logic [7:0] OP_TEXHI  = 8'd21;
  localparam logic [7:0] OP_SPRSEL = 8'd22;
  localparam logic [7:0] OP_POSX   = 8'd23;
  localparam logic [7:0] OP_POSY   = 8'd24;
  localparam logic [7:0] OP_SCLX   = 8'd25;
  localparam logic [7:0] OP_SCLY   = 8'd26;
  localparam logic [7:0] OP_SWPX   = 8'd27;
  localparam logic [7:0] OP_SWPY   = 8'd28;
  localparam logic [7:0] OP_W0CLR  = 8'd29;
  localparam logic [7:0] OP_TEX    = 8'd30;
  localparam logic [7:0] OP_COL1   = 8'd31;
  localparam logic [7:0] OP_COL2   = 8'd32;
  localparam logic [7:0] OP_COL3   = 8'd33;
  localparam logic [7:0] OP_COL4   = 8'd34;
  localparam logic [7:0] OP_W1CLR  = 8'd35;
  localparam logic [7:0] OP_CLM    = 8'd249;

  if (SPR_W + 1 > ADDR_W - 2) begin : g_illegal
    $error("sprite_attr_writer: SPR_W+1 must not exceed TEX_W+YS_W-2");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                wx_q, wx_d;
  logic [31:0]         savex_q, savex_d;
  logic [TEX_W-1:0]    texnum_q, texnum_d;
  logic [YS_W-1:0]     ysline_q, ysline_d;
  logic [15:0]         texlo_q, texlo_d;
  logic [SPR_W-1:0]    sprnum_q, sprnum_d;
  logic [31:0]         shadow_q [SH_N];

  logic                shWe, shClrAll;
  logic [SH_W-1:0]     shAddr;
  logic [31:0]         shData;

  logic [7:0]          op;
  logic [15:0]         arg;
  logic                isSpr, wordSel;
  logic [31:0]         fMask, fVal, merged;
  logic [SH_W-1:0]     spAddr;
  logic [ADDR_W-1:0]   clmAddr;
  logic                clmInSpr;

  assign op       = cmd[23:16];
  assign arg      = cmd[15:0];
  assign spAddr   = {sprnum_q, wordSel};
  assign merged   = (shadow_q[spAddr] & ~fMask) | (fVal & fMask);
  assign clmAddr  = cmd[ADDR_W-1:0];
  assign clmInSpr = (clmAddr[ADDR_W-1:SH_W] == '0);

  // Field position and word select of every sprite opcode.
  always_comb begin
    isSpr   = 1'b1;
    wordSel = 1'b0;
    fMask   = '0;
    fVal    = '0;
    case (op)
      OP_POSX:  begin fMask = 32'hFF80_0000; fVal = {arg[8:0], 23'b0}; end
      OP_POSY:  begin fMask = 32'h007F_8000; fVal = {9'b0, arg[7:0], 15'b0}; end
      OP_SCLX:  begin fMask = 32'h0000_7800; fVal = {17'b0, arg[3:0], 11'b0}; end
      OP_SCLY:  begin fMask = 32'h0000_0780; fVal = {21'b0, arg[3:0], 7'b0}; end
      OP_SWPX:  begin fMask = 32'h0000_0040; fVal = {25'b0, arg[0], 6'b0}; end
      OP_SWPY:  begin fMask = 32'h0000_0020; fVal = {26'b0, arg[0], 5'b0}; end
      OP_W0CLR: begin fMask = '1; end
      OP_TEX:   begin wordSel = 1'b1; fMask = 32'hFC00_0000; fVal = {1'b0, arg[4:0], 26'b0}; end
      OP_COL1:  begin wordSel = 1'b1; fMask = 32'h03E0_0000; fVal = {6'b0, arg[4:0], 21'b0}; end
      OP_COL2:  begin wordSel = 1'b1; fMask = 32'h001F_0000; fVal = {11'b0, arg[4:0], 16'b0}; end
      OP_COL3:  begin wordSel = 1'b1; fMask = 32'h0000_F800; fVal = {16'b0, arg[4:0], 11'b0}; end
      OP_COL4:  begin wordSel = 1'b1; fMask = 32'h0000_07C0; fVal = {21'b0, arg[4:0], 6'b0}; end
      OP_W1CLR: begin wordSel = 1'b1; fMask = '1; end
      default:  isSpr = 1'b0;
    endcase
  end

  // cnt_q holds the address currently on the write port while clearing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    texnum_d = texnum_q;
    ysline_d = ysline_q;
    texlo_d  = texlo_q;
    sprnum_d = sprnum_q;
    wx_d     = 1'b0;
    waddr_d  = waddr_q;
    savex_d  = '0;
    shWe     = 1'b0;
    shClrAll = 1'b0;
    shAddr   = spAddr;
    shData   = merged;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op == OP_CLRALL) begin
            shClrAll = 1'b1;
            cnt_d    = '0;
            wx_d     = 1'b1;
            waddr_d  = '0;
            state_d  = CLEAR;
          end else if (isSpr) begin
            wx_d    = 1'b1;
            waddr_d = ADDR_W'(spAddr);
            savex_d = merged;
            shWe    = 1'b1;
          end else begin
            case (op)
              OP_TEXSEL: if (arg[TEX_W-1:TEX_W-2] != '0) texnum_d = arg[TEX_W-1:0];
              OP_YSEL:   ysline_d = arg[YS_W-1:0];
              OP_TEXLO:  texlo_d = arg;
              OP_TEXHI: begin
                wx_d    = 1'b1;
                waddr_d = {texnum_q, ysline_q};
                savex_d = {texlo_q, arg};
              end
              OP_SPRSEL: sprnum_d = arg[SPR_W-1:0];
              OP_CLM: begin
                wx_d    = 1'b1;
                waddr_d = clmAddr;
                if (clmInSpr) begin
                  shWe   = 1'b1;
                  shAddr = clmAddr[SH_W-1:0];
                  shData = '0;
                end
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        if (cnt_q == '1) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          wx_d    = 1'b1;
          waddr_d = cnt_q + ADDR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      wx_q     <= 1'b0;
      savex_q  <= '0;
      texnum_q <= '0;
      ysline_q <= '0;
      texlo_q  <= '0;
      sprnum_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      wx_q     <= wx_d;
      savex_q  <= savex_d;
      texnum_q <= texnum_d;
      ysline_q <= ysline_d;
      texlo_q  <= texlo_d;
      sprnum_q <= sprnum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SH_N; i++) shadow_q[i] <= '0;
    end else if (shClrAll) begin
      for (int i = 0; i < SH_N; i++) shadow_q[i] <= '0;
    end else if (shWe) begin
      shadow_q[shAddr] <= shData;
    end
  end

  assign wx        = wx_q;
  assign waddrx    = waddr_q;
  assign savex     = savex_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign rdy       = (state_q == DONE);

endmodule

// File: tb/tb_sprite_attr_writer.sv
// Scoreboard bench for sprite_attr_writer: a spec-level model queues expected
// RAM writes at command acceptance, a negedge monitor pops and compares them.
module tb_sprite_attr_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [23:0] cmd;
  logic        cmd_ready, wx, busy, rdy;
  logic [8:0]  waddrx;
  logic [31:0] savex;

  sprite_attr_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .wx(wx), .waddrx(waddrx), .savex(savex),
    .busy(busy), .rdy(rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mReadyAt = 0;
  bit monOn = 1'b0;

  int          qa[$];
  logic [31:0] qd[$];

  logic [31:0] mShadow [64];
  int mTex, mYs, mTexlo, mSpr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h want=0x%08h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic logic [23:0] mk(input int op, input int v);
    return {8'(op), 16'(v)};
  endfunction

  function automatic void push(input int a, input logic [31:0] d);
    qa.push_back(a);
    qd.push_back(d);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) mShadow[i] = '0;
    mTex = 0; mYs = 0; mTexlo = 0; mSpr = 0;
    mReadyAt = 0;
    qa.delete();
    qd.delete();
  endfunction

  // Reference behaviour: field tables and plain arithmetic per opcode.
  function automatic void modelCmd(input logic [23:0] c, input int e);
    int op, opnd, lsb, w, vw, a;
    longint mask, val;
    op = int'(c[23:16]);
    opnd = int'(c[15:0]);
    lsb = 0; w = 0; vw = 0;
    if (op == 36) begin
      for (int i = 0; i < 64; i++) mShadow[i] = '0;
      for (int i = 0; i < 512; i++) push(i, 32'h0);
      mReadyAt = e + 513;
      return;
    end
    case (op)
      18: if ((opnd / 8) % 4 != 0) mTex = opnd % 32;
      19: mYs = opnd % 16;
      20: mTexlo = opnd;
      21: push(mTex * 16 + mYs, 32'(longint'(mTexlo) * 65536 + opnd));
      22: mSpr = opnd % 32;
      249: begin
        a = opnd % 512;
        push(a, 32'h0);
        if (a < 64) mShadow[a] = '0;
      end
      23: begin lsb = 23; w = 9; vw = 9; end
      24: begin lsb = 15; w = 8; vw = 8; end
      25: begin lsb = 11; w = 4; vw = 4; end
      26: begin lsb = 7;  w = 4; vw = 4; end
      27: begin lsb = 6;  w = 1; vw = 1; end
      28: begin lsb = 5;  w = 1; vw = 1; end
      29: begin lsb = 0;  w = 32; vw = 0; end
      30: begin lsb = 26; w = 6; vw = 5; end
      31: begin lsb = 21; w = 5; vw = 5; end
      32: begin lsb = 16; w = 5; vw = 5; end
      33: begin lsb = 11; w = 5; vw = 5; end
      34: begin lsb = 6;  w = 5; vw = 5; end
      35: begin lsb = 0;  w = 32; vw = 0; end
      default: ;
    endcase
    if (op >= 23 && op <= 35) begin
      a = mSpr * 2 + ((op >= 30) ? 1 : 0);
      mask = ((64'd1 << w) - 1) << lsb;
      val = (longint'(opnd) % (64'd1 << vw)) << lsb;
      mShadow[a] = (mShadow[a] & ~32'(mask)) | 32'(val);
      push(a, mShadow[a]);
    end
  endfunction

  // Present one command until the DUT takes it; cmd_ready is checked each cycle.
  task automatic applyStimulus(input logic [23:0] c);
    int waited = 0;
    bit acc = 1'b0;
    int drvCyc = 0;
    while (!acc && waited < 2000) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd = c;
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(cyc >= mReadyAt));
      acc = cmd_ready;
      drvCyc = cyc;
      @(posedge clk);
      waited++;
    end
    #1 cmd_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout cmd=0x%06h not accepted in %0d cycles", c, waited);
    end else begin
      modelCmd(c, drvCyc + 1);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd = 24'($urandom());
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (wx) begin
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write got addr=%0d data=0x%08h want no write", waddrx, savex);
        end else begin
          checkOutput("wr_addr", 32'(waddrx), 32'(qa.pop_front()));
          checkOutput("wr_data", savex, qd.pop_front());
        end
      end else begin
        checkOutput("idle_savex", savex, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int op;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_wx", 32'(wx), 0);
    checkOutput("rst_waddrx", 32'(waddrx), 0);
    checkOutput("rst_savex", savex, 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_rdy", 32'(rdy), 0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b0;
    monOn = 1'b1;

    // Shadow merge across sprite reselection
    applyStimulus(mk(22, 3));  applyStimulus(mk(23, 100));
    applyStimulus(mk(22, 4));  applyStimulus(mk(24, 7));
    applyStimulus(mk(22, 3));  applyStimulus(mk(24, 50));
    // Texture pair with an ignored TEXSEL
    applyStimulus(mk(18, 8));  applyStimulus(mk(18, 3));
    applyStimulus(mk(19, 3));  applyStimulus(mk(20, 16'hABCD));
    applyStimulus(mk(21, 16'h1234));
    // Field isolation on word 1, then w0 of sprite 2 must still be intact
    applyStimulus(mk(22, 2));  applyStimulus(mk(23, 77));
    applyStimulus(mk(30, 5));  applyStimulus(mk(32, 9));
    applyStimulus(mk(35, 0));  applyStimulus(mk(25, 0));
    // Single clear drops the posx already merged
    applyStimulus(mk(23, 1));  applyStimulus(mk(249, 16'h004));
    applyStimulus(mk(24, 1));  applyStimulus(mk(249, 16'h1FF));
    applyStimulus(mk(16, 16'hFFFF));
    idleCycles(3);

    // Bulk clear with a posx command held throughout
    applyStimulus(mk(36, 0));
    fork
      begin
        for (int k = 0; k < 512; k++) begin
          @(negedge clk);
          checkOutput("clr_busy", 32'(busy), 1);
        end
        @(negedge clk);
        checkOutput("done_rdy", 32'(rdy), 1);
        checkOutput("done_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("rdy_pulse_end", 32'(rdy), 0);
      end
      applyStimulus(mk(23, 300));
    join
    idleCycles(3);

    // Random command mix at full throughput with occasional gaps
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 19));
      if (op < 18) op = op + 18;
      else if (op == 18) op = 249;
      else op = (($urandom_range(0, 1) == 0) ? 15 : 37);
      applyStimulus(mk(op, int'($urandom_range(0, 65535))));
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
    end
    idleCycles(3);

    // Reset in the middle of a bulk clear
    applyStimulus(mk(36, 0));
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst_wx", 32'(wx), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(10);
    applyStimulus(mk(23, 5));
    applyStimulus(mk(31, 17));
    idleCycles(4);

    checkOutput("queue_empty", 32'(qa.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
